// File: rtl/fir_filter_mac_acc_pkg.sv
// Shared types and helpers for the FIR output accumulator stage.
package fir_filter_pkg;

    localparam int FIR_PROD_WIDTH = 36;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } fir_state_e;

    // One spare bit above what NUM_TAPS needs, so a saturated count can never alias NUM_TAPS.
    function automatic int fir_cnt_width(input int num_taps);
        return $clog2(num_taps + 1) + 1;
    endfunction

endpackage

// File: rtl/fir_filter_mac_acc_if.sv
// Product-in / sample-out valid-ready bundle for the FIR accumulator stage.
interface fir_filter_mac_acc_if #(
    parameter int PROD_WIDTH = 36,
    parameter int OUT_WIDTH  = 18
);
    logic [PROD_WIDTH-1:0] prod_din;
    logic                  prod_valid;
    logic                  prod_last;
    logic                  prod_ready;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  out_err;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output prod_din, prod_valid, prod_last, out_ready,
        input  prod_ready, out_data, out_err, out_valid
    );

    modport slave (
        input  prod_din, prod_valid, prod_last, out_ready,
        output prod_ready, out_data, out_err, out_valid
    );
endinterface

// File: rtl/fir_filter_mac_acc_rndsat.sv
// Final-sum scaling: round half toward +inf, arithmetic shift, clamp to OUT_WIDTH.
module fir_filter_mac_acc_rndsat #(
    parameter int ACC_WIDTH = 48,
    parameter int SHIFT     = 17,
    parameter int OUT_WIDTH = 18
) (
    input  logic signed [ACC_WIDTH-1:0] sum,
    output logic signed [OUT_WIDTH-1:0] res
);
    localparam logic signed [ACC_WIDTH:0] MAXV =
        {{(ACC_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] MINV =
        {{(ACC_WIDTH+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] r;

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic [ACC_WIDTH:0] HALF = (ACC_WIDTH+1)'(1) << (SHIFT-1);
            // One extra bit so the rounding add cannot wrap near the positive limit.
            logic signed [ACC_WIDTH:0] rnd;
            assign rnd = {sum[ACC_WIDTH-1], sum} + HALF;
            assign r   = rnd >>> SHIFT;
        end else begin : g_pass
            assign r = {sum[ACC_WIDTH-1], sum};
        end
    endgenerate

    always_comb begin
        res = r[OUT_WIDTH-1:0];
        if (r > MAXV)
            res = MAXV[OUT_WIDTH-1:0];
        else if (r < MINV)
            res = MINV[OUT_WIDTH-1:0];
    end

endmodule

// File: rtl/fir_filter_mac_acc.sv
// Accumulates a frame of signed products into one scaled output sample per prod_last,
// with a registered valid/ready output and a frame-length error flag.
module fir_filter_mac_acc
    import fir_filter_pkg::*;
#(
    parameter int NUM_TAPS   = 16,
    parameter int PROD_WIDTH = FIR_PROD_WIDTH,
    parameter int ACC_WIDTH  = 48,
    parameter int SHIFT      = 17,
    parameter int OUT_WIDTH  = 18
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    fir_filter_mac_acc_if.slave  bus,
    output logic                 busy
);
    localparam int            CW      = fir_cnt_width(NUM_TAPS);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TAPS_C  = CW'(NUM_TAPS);

    fir_state_e                  state;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc_in;
    logic signed [ACC_WIDTH-1:0] sum;
    logic [CW-1:0]               tap_cnt;
    logic [CW-1:0]               cnt_inc;
    logic signed [OUT_WIDTH-1:0] rs;
    logic signed [OUT_WIDTH-1:0] out_data_q;
    logic                        out_valid_q;
    logic                        out_err_q;
    logic                        take;

    assign bus.prod_ready = !out_valid_q || bus.out_ready;
    assign take           = bus.prod_valid && bus.prod_ready;

    assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){bus.prod_din[PROD_WIDTH-1]}}, bus.prod_din};
    assign acc_in   = (state == ST_ACCUM) ? acc : '0;
    assign sum      = acc_in + prod_ext;
    // Saturating count: an overlong frame must never wrap back onto NUM_TAPS.
    assign cnt_inc  = (tap_cnt == CNT_MAX) ? tap_cnt : tap_cnt + 1'b1;

    fir_filter_mac_acc_rndsat #(
        .ACC_WIDTH (ACC_WIDTH),
        .SHIFT     (SHIFT),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_rndsat (
        .sum (sum),
        .res (rs)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state       <= ST_IDLE;
            acc         <= '0;
            tap_cnt     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready)
                out_valid_q <= 1'b0;
            // A last beat in the same cycle as a drain reloads the register, keeping out_valid high.
            if (take) begin
                if (bus.prod_last) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= rs;
                    out_err_q   <= (cnt_inc != TAPS_C);
                    acc         <= '0;
                    tap_cnt     <= '0;
                    state       <= ST_IDLE;
                end else begin
                    acc         <= sum;
                    tap_cnt     <= cnt_inc;
                    state       <= ST_ACCUM;
                end
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = (tap_cnt != '0);

endmodule
